line_mem_responder: RTL and testbench

//  Memory-side responder for the mutative cache's 256-bit line port (dfp_*). Accepts one line read or

---
 rtl/mutative_types_pkg.sv | 21 ++
 rtl/line_mem_responder_line_store.sv | 32 +++
 rtl/line_mem_responder.sv | 122 ++++++++++++
 tb/tb_line_mem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mutative_types_pkg.sv
// Shared types for the mutative cache memory side: line width, memory op kinds
// and the responder FSM state encoding.
package mutative_types;

    localparam int OFFSET_BITS = 5;
    localparam int LINE_BITS   = 256;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic {
        MEM_RD,
        MEM_WR
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } resp_state_e;

endpackage

// File: rtl/line_mem_responder_line_store.sv
// Flop-based backing store of whole cache lines: one combinational read port,
// one synchronous write port, cleared to zero by the active-low reset.
import mutative_types::*;

module line_store #(
    parameter int LINES    = 64,
    parameter int IDX_BITS = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [LINE_BITS-1:0] wr_data
);

    line_t mem [LINES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LINES; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory model for the cache line port: accepts one line read/write at a
// time and answers with a one-cycle dfp_resp a fixed LATENCY cycles later.
import mutative_types::*;

module line_mem_responder #(
    parameter int LINES   = 64,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic                 proto_err,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 1);

    resp_state_e          state;
    resp_state_e          next_state;
    logic [CNT_BITS-1:0]  cnt;
    mem_op_e              op;
    logic [IDX_BITS-1:0]  idx;
    line_t                wdata_q;
    line_t                store_rdata;
    logic                 accept;
    logic                 commit;
    logic                 unused_addr_bits;

    assign accept = (state == ST_IDLE) && (dfp_read || dfp_write);

    // Offset bits and everything above the index alias onto the same line.
    assign unused_addr_bits = ^{dfp_addr[OFFSET_BITS-1:0], dfp_addr[31:OFFSET_BITS+IDX_BITS]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_BITS'(1)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        dfp_resp  = (state == ST_RESP);
        commit    = dfp_resp && (op == MEM_WR);
        dfp_rdata = '0;
        if (dfp_resp && (op == MEM_RD)) begin
            dfp_rdata = store_rdata;
        end
    end

    // Request latch: a simultaneous read+write is flagged and then treated as a write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            op        <= MEM_RD;
            idx       <= '0;
            wdata_q   <= '0;
            proto_err <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            if (accept) begin
                op      <= dfp_write ? MEM_WR : MEM_RD;
                idx     <= dfp_addr[OFFSET_BITS +: IDX_BITS];
                wdata_q <= dfp_wdata;
                cnt     <= CNT_INIT;
                if (dfp_read && dfp_write) begin
                    proto_err <= 1'b1;
                end
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CNT_BITS'(1);
            end
            if (state == ST_RESP) begin
                if (op == MEM_RD) begin
                    rd_count <= rd_count + 32'd1;
                end else begin
                    wr_count <= wr_count + 32'd1;
                end
            end
        end
    end

    line_store #(
        .LINES    (LINES),
        .IDX_BITS (IDX_BITS)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx),
        .rd_data (store_rdata),
        .wr_en   (commit),
        .wr_idx  (idx),
        .wr_data (wdata_q)
    );

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: a LATENCY=4 instance for functional
// checks plus a LATENCY=1 instance for back-to-back spacing.
module tb_line_mem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic [31:0]  dfp_addr  = '0;
    logic         dfp_read  = 1'b0;
    logic         dfp_write = 1'b0;
    logic [255:0] dfp_wdata = '0;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         proto_err;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    logic [31:0]  f_addr  = '0;
    logic         f_read  = 1'b0;
    logic         f_write = 1'b0;
    logic [255:0] f_wdata = '0;
    logic [255:0] f_rdata;
    logic         f_resp;
    logic         f_proto_err;
    logic [31:0]  f_rd_count;
    logic [31:0]  f_wr_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_mem_responder #(.LINES(64), .LATENCY(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .dfp_addr  (dfp_addr),
        .dfp_read  (dfp_read),
        .dfp_write (dfp_write),
        .dfp_wdata (dfp_wdata),
        .dfp_rdata (dfp_rdata),
        .dfp_resp  (dfp_resp),
        .proto_err (proto_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    line_mem_responder #(.LINES(64), .LATENCY(1)) dut_fast (
        .clk       (clk),
        .rst       (rst),
        .dfp_addr  (f_addr),
        .dfp_read  (f_read),
        .dfp_write (f_write),
        .dfp_wdata (f_wdata),
        .dfp_rdata (f_rdata),
        .dfp_resp  (f_resp),
        .proto_err (f_proto_err),
        .rd_count  (f_rd_count),
        .wr_count  (f_wr_count)
    );

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge in IDLE; returns the cycle (1-based after acceptance) of dfp_resp.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [255:0] wdata, input bit change_mid,
                                 output int lat, output logic [255:0] rdata);
        lat       = 0;
        rdata     = '0;
        dfp_read  = rd;
        dfp_write = wr;
        dfp_addr  = addr;
        dfp_wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (change_mid && k == 2) begin
                dfp_addr  = addr ^ 32'h0000_00C0;
                dfp_wdata = ~wdata;
            end
            if (dfp_resp) begin
                lat   = k;
                rdata = dfp_rdata;
                break;
            end
        end
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        if (lat == 0) $display("[TB] no dfp_resp within 20 cycles of %h", addr);
        @(negedge clk);
        checkOutput("resp_single_cycle", {255'd0, dfp_resp}, 256'd0);
    endtask

    initial begin
        int           lat;
        logic [255:0] rdata;
        logic [255:0] dead;
        logic [5:0]   pattern;

        dead = {8{32'hDEADBEEF}};

        // Reset held for two edges
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_resp",      {255'd0, dfp_resp}, 256'd0);
        checkOutput("reset_rdata",     dfp_rdata, 256'd0);
        checkOutput("reset_rd_count",  {224'd0, rd_count}, 256'd0);
        checkOutput("reset_wr_count",  {224'd0, wr_count}, 256'd0);
        checkOutput("reset_proto_err", {255'd0, proto_err}, 256'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, lat, rdata);
        checkOutput("rd40_latency", 256'(lat), 256'd4);
        checkOutput("rd40_data", rdata, 256'd0);
        checkOutput("rd40_rd_count", {224'd0, rd_count}, 256'd1);

        applyStimulus(1'b0, 1'b1, 32'h0000_0080, dead, 1'b0, lat, rdata);
        checkOutput("wr80_latency", 256'(lat), 256'd4);
        checkOutput("wr80_rdata_zero", rdata, 256'd0);
        checkOutput("wr80_wr_count", {224'd0, wr_count}, 256'd1);

        applyStimulus(1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, lat, rdata);
        checkOutput("rd80_latency", 256'(lat), 256'd4);
        checkOutput("rd80_data", rdata, dead);
        checkOutput("rd80_rd_count", {224'd0, rd_count}, 256'd2);

        // Alias write to index 0, with inputs disturbed mid-BUSY
        applyStimulus(1'b0, 1'b1, 32'h0000_0800, 256'h1, 1'b1, lat, rdata);
        checkOutput("wr800_latency", 256'(lat), 256'd4);
        checkOutput("wr800_wr_count", {224'd0, wr_count}, 256'd2);

        applyStimulus(1'b1, 1'b0, 32'h0000_0000, '0, 1'b1, lat, rdata);
        checkOutput("rd0_alias_data", rdata, 256'h1);
        checkOutput("rd0_rd_count", {224'd0, rd_count}, 256'd3);

        applyStimulus(1'b1, 1'b0, 32'h0000_00C0, '0, 1'b0, lat, rdata);
        checkOutput("rdC0_untouched", rdata, 256'd0);

        // Read and write together
        applyStimulus(1'b1, 1'b1, 32'h0000_0020, 256'hA5, 1'b0, lat, rdata);
        checkOutput("rw20_latency", 256'(lat), 256'd4);
        checkOutput("rw20_proto_err", {255'd0, proto_err}, 256'd1);
        checkOutput("rw20_wr_count", {224'd0, wr_count}, 256'd3);
        checkOutput("rw20_rd_count", {224'd0, rd_count}, 256'd4);

        applyStimulus(1'b1, 1'b0, 32'h0000_0020, '0, 1'b0, lat, rdata);
        checkOutput("rd20_data", rdata, 256'hA5);
        checkOutput("rd20_proto_sticky", {255'd0, proto_err}, 256'd1);
        checkOutput("rd20_rd_count", {224'd0, rd_count}, 256'd5);

        // Reset two cycles into a write aborts it
        dfp_write = 1'b1;
        dfp_addr  = 32'h0000_0060;
        dfp_wdata = 256'h77;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_resp_k1", {255'd0, dfp_resp}, 256'd0);
        @(negedge clk);
        rst       = 1'b0;
        dfp_write = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checkOutput("abort_no_resp", {255'd0, dfp_resp}, 256'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_wr_count", {224'd0, wr_count}, 256'd0);
        checkOutput("abort_proto_err", {255'd0, proto_err}, 256'd0);

        applyStimulus(1'b1, 1'b0, 32'h0000_0060, '0, 1'b0, lat, rdata);
        checkOutput("rd60_latency", 256'(lat), 256'd4);
        checkOutput("rd60_no_commit", rdata, 256'd0);
        checkOutput("rd60_rd_count", {224'd0, rd_count}, 256'd1);

        applyStimulus(1'b1, 1'b0, 32'h0000_0020, '0, 1'b0, lat, rdata);
        checkOutput("rd20_cleared", rdata, 256'd0);

        // LATENCY=1 instance with the request held continuously
        f_read = 1'b1;
        f_addr = 32'h0000_0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pattern[k] = f_resp;
        end
        f_read = 1'b0;
        checkOutput("fast_resp_pattern", {250'd0, pattern}, {250'd0, 6'b010101});
        checkOutput("fast_rd_count", {224'd0, f_rd_count}, 256'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
